ps2_tx: RTL and testbench
=========================

// Module: ps2_tx
// PURPOSE
//  Host-to-device PS/2 transmitter; sends command bytes to keyboard/mouse (e.g. 0xED LEDs, 0xF4 enable).
//  Sits beside the PS/2 receiver on the same open-drain clock/data pair; top level ties *_OE to tri-state pads.
//  Performs the full frame: clock inhibit, request-to-send, 8 data bits LSB first, odd parity, stop, device ACK.
// PARAMETERS
//  INHIBIT_CYCLES  5000    iCLK cycles PS/2 clock is held low before request (100 us @ 50 MHz)
//  TIMEOUT_CYCLES  750000  watchdog limit for whole frame after inhibit (15 ms @ 50 MHz); used only with PS2TX_TIMEOUT_EN
// PORTS
//  iCLK       in   1  system clock
//  iRST_N     in   1  synchronous reset, active low
//  iPS2CLK    in   1  PS/2 clock line as seen at pad
//  iPS2DAT    in   1  PS/2 data line as seen at pad
//  iSTART     in   1  1-cycle request; iDATA captured when oBUSY=0
//  iDATA      in   8  byte to send
//  oPS2CLK_OE out  1  1 = drive PS/2 clock low; 0 = release (pull-up)
//  oPS2DAT_OE out  1  1 = drive PS/2 data low; 0 = release
//  oBUSY      out  1  high from accepted iSTART until cycle after oDONE
//  oDONE      out  1  1-cycle pulse at frame end (success or failure)
//  oERR       out  1  1-cycle pulse coincident with oDONE on failure (NACK or timeout)
// BEHAVIOUR
//  - Reset (iRST_N=0 at posedge iCLK): state IDLE, all outputs 0, both lines released, counters cleared.
//    Reset mid-frame aborts immediately; no oDONE/oERR emitted.
//  - iPS2CLK/iPS2DAT pass through 2-flop synchronizers; fall = synced clock sequence 2'b10.
//  - iSTART while oBUSY=1 ignored. Accepted iSTART latches iDATA and parity p = ~^iDATA (odd).
//  - States:
//    IDLE:    outputs 0. iSTART -> INHIBIT, oBUSY=1 next cycle.
//    INHIBIT: oPS2CLK_OE=1, oPS2DAT_OE=0 for INHIBIT_CYCLES cycles; on final cycle oPS2DAT_OE=1 -> REQ.
//    REQ:     oPS2CLK_OE=0, oPS2DAT_OE=1 (start bit 0). Each fall advances bit counter n (0..10).
//    SEND:    on fall n=1..8 present data bit n-1; n=9 parity; n=10 stop (oPS2DAT_OE=0).
//             Line value v is encoded as oPS2DAT_OE = ~v, updated cycle after detected fall.
//    ACK:     on fall n=11 sample synced data: 0 = ACK, 1 = NACK. -> RELEASE.
//    RELEASE: wait until synced clock=1 and data=1, then oDONE=1 (oERR=1 if NACK) -> IDLE.
//  - Host never drives clock low after INHIBIT; only the device clocks the frame.
//  - Device clocks arriving in IDLE are ignored (receiver handles them).
//  - Counter widths: inhibit/timeout counters sized by $clog2 of parameter; bit counter 4 bits.
//  - Latency: iSTART to first pad drive = 1 cycle; oDONE = 1 cycle after line-release detection.
// CONFIGURATION
//  PS2TX_TIMEOUT_EN defined: watchdog counts every cycle in REQ/SEND/ACK/RELEASE; reaching
//   TIMEOUT_CYCLES releases both lines next cycle, pulses oDONE+oERR, returns to IDLE.
//  Undefined: no watchdog; block waits indefinitely for device clocks; oERR only on NACK.
// TESTING
//  1. Send 0xF4, device model ACKs -> data bits 0,0,1,0,1,1,1,1, parity 0, stop 1; oDONE=1, oERR=0.
//  2. Send 0xED -> parity bit 1; send 0x00 -> parity 1; check clock held low exactly INHIBIT_CYCLES.
//  3. Device leaves data high at 11th fall -> oDONE=1, oERR=1, lines released, oBUSY falls next cycle.
//  4. iSTART pulsed again while oBUSY=1 with 0xAA -> ignored, original byte sent unchanged.
//  5. iRST_N=0 during bit 4 -> next cycle both OE=0, oBUSY=0, no oDONE; new iSTART works normally.
//  6. PS2TX_TIMEOUT_EN, TIMEOUT_CYCLES=2000, device never clocks -> oDONE+oERR at 2000 cycles post-REQ.

Source files
------------

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits LSB first, odd parity, stop, ACK.
// Define PS2TX_TIMEOUT_EN to add a whole-frame watchdog (TIMEOUT_CYCLES) that ends the frame with an error.
module ps2_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iPS2CLK,
  input  logic       iPS2DAT,
  input  logic       iSTART,
  input  logic [7:0] iDATA,
  output logic       oPS2CLK_OE,
  output logic       oPS2DAT_OE,
  output logic       oBUSY,
  output logic       oDONE,
  output logic       oERR
);

  localparam int unsigned IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);

  if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("ps2_tx: INHIBIT_CYCLES must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic [IW-1:0] r_inh_cnt;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_data;
  logic          r_par;
  logic          r_txbit;
  logic          r_nack;
  logic          r_done;
  logic          r_err;

  logic w_fall;
  logic w_clk_hi;
  logic w_dat_hi;
  logic w_accept;
  logic w_timeout;
  logic w_done_set;
  logic w_err_set;
  logic w_bit_sel;

  assign w_clk_hi = r_clk_sync[1];
  assign w_dat_hi = r_dat_sync[1];
  assign w_fall   = (r_clk_sync[2:1] == 2'b10);

  // oDONE is registered while the state is already IDLE, so busy has to cover that cycle too.
  assign oBUSY    = (r_state != S_IDLE) | r_done;
  assign w_accept = iSTART & ~oBUSY;
  assign oDONE    = r_done;
  assign oERR     = r_err;

`ifdef PS2TX_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_wdog;
  logic          w_wd_active;

  assign w_wd_active = (r_state == S_REQ) || (r_state == S_SEND) ||
                       (r_state == S_ACK) || (r_state == S_RELEASE);
  assign w_timeout   = w_wd_active && (r_wdog == TO_LAST);

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= w_wd_active ? r_wdog + 1'b1 : '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_set  = 1'b0;
    w_err_set   = 1'b0;
    unique case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = S_INHIBIT;
      S_INHIBIT: if (r_inh_cnt == INH_LAST) w_state_nxt = S_REQ;
      S_REQ:     if (w_fall) w_state_nxt = S_SEND;
      S_SEND:    if (w_fall && r_bit_cnt == 4'd9) w_state_nxt = S_ACK;
      S_ACK:     if (w_fall) w_state_nxt = S_RELEASE;
      S_RELEASE: begin
        if (w_clk_hi && w_dat_hi) begin
          w_state_nxt = S_IDLE;
          w_done_set  = 1'b1;
          w_err_set   = r_nack;
        end
      end
      default:   w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_done_set  = 1'b1;
      w_err_set   = 1'b1;
    end
  end

  always_comb begin
    oPS2CLK_OE = 1'b0;
    oPS2DAT_OE = 1'b0;
    unique case (r_state)
      S_INHIBIT: begin
        oPS2CLK_OE = 1'b1;
        oPS2DAT_OE = (r_inh_cnt == INH_LAST);
      end
      S_REQ:     oPS2DAT_OE = 1'b1;
      S_SEND:    oPS2DAT_OE = ~r_txbit;
      default:   ;
    endcase
  end

  // r_bit_cnt holds falls seen so far; the bit selected here is the one for the next fall.
  always_comb begin
    w_bit_sel = 1'b1;
    if (r_bit_cnt < 4'd8) begin
      w_bit_sel = r_data[r_bit_cnt[2:0]];
    end else if (r_bit_cnt == 4'd8) begin
      w_bit_sel = r_par;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_inh_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_data     <= '0;
      r_par      <= 1'b0;
      r_txbit    <= 1'b0;
      r_nack     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], iPS2CLK};
      r_dat_sync <= {r_dat_sync[0], iPS2DAT};
      r_done     <= w_done_set;
      r_err      <= w_err_set;
      r_inh_cnt  <= (r_state == S_INHIBIT) ? r_inh_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_data <= iDATA;
        r_par  <= ~^iDATA;
      end
      if (r_state == S_IDLE) begin
        r_bit_cnt <= '0;
        r_nack    <= 1'b0;
      end
      if ((r_state == S_REQ || r_state == S_SEND) && w_fall) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
        r_txbit   <= w_bit_sel;
      end
      if (r_state == S_ACK && w_fall) begin
        r_nack <= w_dat_hi;
      end
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Scoreboard bench for ps2_tx: open-drain bus model plus a behavioural PS/2 device that clocks the frame.
module tb_ps2_tx;
  localparam int unsigned INH = 64;
  localparam int unsigned TO  = 2000;
  localparam int H = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] data;
  logic       clk_oe, dat_oe, busy, done, err;
  logic       dev_clk_low, dev_dat_low;
  logic       ps2clk, ps2dat;

  always #5 clk = ~clk;

  assign ps2clk = ~(clk_oe | dev_clk_low);
  assign ps2dat = ~(dat_oe | dev_dat_low);

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iPS2CLK(ps2clk), .iPS2DAT(ps2dat),
    .iSTART(start), .iDATA(data), .oPS2CLK_OE(clk_oe), .oPS2DAT_OE(dat_oe),
    .oBUSY(busy), .oDONE(done), .oERR(err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  typedef struct {
    logic [7:0] b;
    bit         err;
    bit         no_frame;
  } exp_t;

  exp_t        q_exp[$];
  logic [10:0] q_obs[$];

  // Wire frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    int ones;
    bit par;
    ones = $countones(b);
    par  = (ones % 2 == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  exp_t mon_e;
  bit   chk_busy = 0;

  always @(negedge clk) begin
    if (chk_busy) begin
      check("busy_after_done", busy, 0);
      chk_busy = 0;
    end
    if (err) check("err_implies_done", done, 1);
    if (done) begin
      if (q_exp.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        mon_e = q_exp.pop_front();
        check("err_flag", err, mon_e.err);
        check("clk_released", clk_oe, 0);
        check("dat_released", dat_oe, 0);
        check("busy_at_done", busy, 1);
        if (!mon_e.no_frame) begin
          check("frame_present", (q_obs.size() > 0), 1);
          if (q_obs.size() > 0) check("frame_bits", q_obs.pop_front(), ref_frame(mon_e.b));
        end
        chk_busy = 1;
      end
    end
  end

  // Behavioural device: measures inhibit, samples each bit late in the clock-low phase, ACKs or NACKs.
  task automatic dev_frame(input bit nack, input int abort_at, input int restart_at);
    int n;
    logic [10:0] fr;
    logic last_dat;
    fr = '0;
    n = 0;
    last_dat = 1'b0;
    while (clk_oe === 1'b1 && n < 4 * INH) begin
      if (n == restart_at) begin
        start = 1'b1;
        data  = 8'hAA;
      end else begin
        start = 1'b0;
      end
      last_dat = dat_oe;
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    check("inhibit_len", n, INH);
    check("inhibit_last_dat", last_dat, 1);
    check("req_start_drive", dat_oe, 1);
    repeat (4) @(negedge clk);
    fr[0] = ps2dat;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) begin
        dev_dat_low = !nack;
        repeat (2) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      if (k <= 10) fr[k] = ps2dat;
      if (k == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dev_clk_low = 1'b0;
        check("abort_clk_oe", clk_oe, 0);
        check("abort_dat_oe", dat_oe, 0);
        check("abort_busy", busy, 0);
        repeat (2 * H) @(negedge clk);
        return;
      end
      if (k == 10) q_obs.push_back(fr);
      dev_clk_low = 1'b0;
      if (k == 11) begin
        repeat (2) @(negedge clk);
        dev_dat_low = 1'b0;
      end
      repeat (H) @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit nack, input int abort_at, input int restart_at);
    exp_t e;
    int w;
    if (abort_at == 0) begin
      e.b = b;
      e.err = nack;
      e.no_frame = 0;
      q_exp.push_back(e);
    end
    data  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data  = 8'($urandom);
    check("start_clk_oe", clk_oe, 1);
    check("start_busy", busy, 1);
    dev_frame(nack, abort_at, restart_at);
    w = 0;
    while (busy === 1'b1 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("busy_clears", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    data  = '0;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_clk_oe", clk_oe, 0);
    check("rst_dat_oe", dat_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    // Device clocks while idle must not start anything.
    for (int i = 0; i < 3; i++) begin
      dev_clk_low = 1'b1;
      repeat (8) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (8) @(negedge clk);
    end
    check("idle_busy", busy, 0);
    check("idle_dat_oe", dat_oe, 0);

    send(8'hF4, 1'b0, 0, -1);
    send(8'hED, 1'b0, 0, -1);
    send(8'h00, 1'b0, 0, -1);
    send(8'h5A, 1'b1, 0, -1);
    send(8'h3C, 1'b0, 0, 10);
    send(8'hC3, 1'b0, 5, -1);
    send(8'h81, 1'b0, 0, -1);

    for (int i = 0; i < 8; i++) begin
      send(8'($urandom), ($urandom_range(0, 3) == 0), 0, -1);
    end

`ifdef PS2TX_TIMEOUT_EN
    begin
      exp_t e;
      int n;
      e.b = 8'h11;
      e.err = 1;
      e.no_frame = 1;
      q_exp.push_back(e);
      data  = 8'h11;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (clk_oe === 1'b1 && n < 4 * INH) begin
        @(negedge clk);
        n++;
      end
      n = 0;
      while (done !== 1'b1 && n < TO + 100) begin
        n++;
        @(negedge clk);
      end
      check("timeout_cycles", n, TO);
      repeat (4) @(negedge clk);
      check("timeout_busy", busy, 0);
    end
`endif

    repeat (10) @(negedge clk);
    check("scoreboard_drained", q_exp.size(), 0);
    check("obs_drained", q_obs.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
